decode_uopq_mw: RTL and testbench

DECODE_UOPQ_MW -- requirements
Module: decode_uopq_mw

---
 rtl/decode_uopq_mw.sv | 151 +++++++++++++++
 tb/tb_decode_uopq_mw.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/decode_uopq_mw.sv
// Multi-lane decode-to-rename uop queue: circular buffer accepting up to NLANE_IN uops
// per cycle and delivering up to NLANE_OUT in order, with EBREAK push blocking and flush.
package decode_uopq_pkg;
    localparam logic [7:0] U_EBREAK = 8'hEB;

    typedef struct packed {
        logic valid;
    } t_nuke_pkt;

    typedef struct packed {
        logic        valid;
        logic [7:0]  uop;
        logic [15:0] imm;
    } t_uinstr;
endpackage

module decode_uopq_mw
    import decode_uopq_pkg::*;
#(
    parameter int NLANE_IN  = 2,
    parameter int NLANE_OUT = 2,
    parameter int DEPTH     = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  t_nuke_pkt                        nuke_rb1,
    input  logic [NLANE_IN-1:0]              valid_de0,
    input  t_uinstr [NLANE_IN-1:0]           uinstr_de0,
    output logic                             decode_ready_de0,
    input  logic [$clog2(NLANE_OUT+1)-1:0]   num_ready_rn0,
    output logic [NLANE_OUT-1:0]             valid_de1,
    output t_uinstr [NLANE_OUT-1:0]          uinstr_de1,
    output logic                             ebreak_blocked,
    output logic [$clog2(DEPTH+1)-1:0]       occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic          eb_q, eb_d;
    t_uinstr       mem_q [DEPTH];
    t_uinstr       mem_d [DEPTH];

    logic          push_en;
    logic          ebreak_push;
    logic          stop;
    logic [OW-1:0] n_push;
    logic [OW-1:0] n_pop;

    // Readiness looks only at registered occupancy, so push never depends on pop.
    assign decode_ready_de0 = !reset && ((int'(occ_q) + NLANE_IN) <= DEPTH);
    assign push_en          = decode_ready_de0 && !nuke_rb1.valid && !eb_q;
    assign ebreak_blocked   = eb_q;
    assign occupancy        = occ_q;

    always_comb begin
        mem_d       = mem_q;
        n_push      = '0;
        stop        = 1'b0;
        ebreak_push = 1'b0;
        for (int i = 0; i < NLANE_IN; i++) begin
            if (push_en && valid_de0[i] && !stop) begin
                mem_d[wr_ptr_q + PW'(n_push)] = uinstr_de0[i];
                n_push = n_push + OW'(1);
                if (uinstr_de0[i].uop == U_EBREAK) begin
                    stop        = 1'b1;
                    ebreak_push = 1'b1;
                end
            end
        end
    end

    always_comb begin
        n_pop = '0;
        if (!reset && !nuke_rb1.valid) begin
            n_pop = occ_q;
            if (n_pop > OW'(num_ready_rn0)) n_pop = OW'(num_ready_rn0);
            if (n_pop > OW'(NLANE_OUT))     n_pop = OW'(NLANE_OUT);
        end
        for (int i = 0; i < NLANE_OUT; i++) begin
            valid_de1[i]  = (OW'(i) < n_pop);
            uinstr_de1[i] = '0;
            if (valid_de1[i]) begin
                uinstr_de1[i]       = mem_q[rd_ptr_q + PW'(i)];
                uinstr_de1[i].valid = 1'b1;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(n_push);
        rd_ptr_d = rd_ptr_q + PW'(n_pop);
        occ_d    = occ_q + n_push - n_pop;
        eb_d     = eb_q | ebreak_push;
        if (nuke_rb1.valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
            eb_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            eb_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            eb_q     <= eb_d;
        end
    end

    // Entry storage is never observed while invalid, so it carries no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef ASSERT
`ifndef VASSERT
`define VASSERT(msg) $error("VASSERT: %s", msg)
`endif
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ((valid_de0 & (valid_de0 + NLANE_IN'(1))) == '0)
            else `VASSERT("non-contiguous valid_de0");
        end
    end
`endif

`ifdef SIMULATION
`ifndef SIMID
`define SIMID 0
`endif
`ifndef UINFO
`define UINFO(msg) $display("[UINFO %0d] %s", `SIMID, msg)
`endif
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (n_push != '0) `UINFO($sformatf("push %0d at wr %0d", n_push, wr_ptr_q));
            if (n_pop != '0)  `UINFO($sformatf("pop %0d at rd %0d", n_pop, rd_ptr_q));
            if (occ_q != '0 && n_pop == '0) `UINFO($sformatf("head stalled occ %0d", occ_q));
        end
    end
`endif
endmodule

// File: tb/tb_decode_uopq_mw.sv
// Randomized bench for decode_uopq_mw, checked each cycle against a queue-based model
// of the uop queue's push, pop, EBREAK-block, nuke and reset rules.
module tb_decode_uopq_mw;
    import decode_uopq_pkg::*;

    localparam int NI = 2;
    localparam int NO = 2;
    localparam int D  = 8;

    logic                          clk;
    logic                          reset;
    t_nuke_pkt                     nuke_rb1;
    logic [NI-1:0]                 valid_de0;
    t_uinstr [NI-1:0]              uinstr_de0;
    logic                          decode_ready_de0;
    logic [$clog2(NO+1)-1:0]       num_ready_rn0;
    logic [NO-1:0]                 valid_de1;
    t_uinstr [NO-1:0]              uinstr_de1;
    logic                          ebreak_blocked;
    logic [$clog2(D+1)-1:0]        occupancy;

    decode_uopq_mw #(.NLANE_IN(NI), .NLANE_OUT(NO), .DEPTH(D)) dut (
        .clk              (clk),
        .reset            (reset),
        .nuke_rb1         (nuke_rb1),
        .valid_de0        (valid_de0),
        .uinstr_de0       (uinstr_de0),
        .decode_ready_de0 (decode_ready_de0),
        .num_ready_rn0    (num_ready_rn0),
        .valid_de1        (valid_de1),
        .uinstr_de1       (uinstr_de1),
        .ebreak_blocked   (ebreak_blocked),
        .occupancy        (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    t_uinstr model_q[$];
    bit      model_eb;
    bit      state_known;
    int      checks;
    int      errors;
    int      seq_id;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drives one cycle's inputs at the negedge, checks outputs against the model, then
    // advances the model to the state the coming posedge should produce.
    task automatic applyStimulus(input bit rst, input bit nk, input int nvalid,
                                 input int eb_lane, input int nready);
        int      n;
        bit      exp_ready;
        t_uinstr e;
        logic [NO-1:0] emask;
        reset          = rst;
        nuke_rb1.valid = nk;
        num_ready_rn0  = ($clog2(NO+1))'(nready);
        for (int i = 0; i < NI; i++) begin
            valid_de0[i]        = (i < nvalid);
            uinstr_de0[i].valid = (i < nvalid);
            uinstr_de0[i].uop   = 8'($urandom_range(0, 255));
            if (uinstr_de0[i].uop == U_EBREAK) uinstr_de0[i].uop = 8'h00;
            if (i == eb_lane) uinstr_de0[i].uop = U_EBREAK;
            uinstr_de0[i].imm   = 16'(seq_id);
            seq_id++;
        end
        #1;
        exp_ready = !rst && (model_q.size() + NI <= D);
        n = 0;
        if (!rst && !nk) begin
            n = model_q.size();
            if (nready < n) n = nready;
            if (NO < n) n = NO;
        end
        emask = NO'((1 << n) - 1);
        checkOutput("decode_ready_de0", 64'(decode_ready_de0), 64'(exp_ready));
        checkOutput("valid_de1", 64'(valid_de1), 64'(emask));
        for (int i = 0; i < NO; i++) begin
            e = '0;
            if (i < n) begin
                e       = model_q[i];
                e.valid = 1'b1;
            end
            checkOutput($sformatf("uinstr_de1[%0d]", i), 64'(uinstr_de1[i]), 64'(e));
        end
        if (state_known) begin
            checkOutput("occupancy", 64'(occupancy), 64'(model_q.size()));
            checkOutput("ebreak_blocked", 64'(ebreak_blocked), 64'(model_eb));
        end
        if (rst || nk) begin
            model_q.delete();
            model_eb = 1'b0;
            if (rst) state_known = 1'b1;
        end else begin
            bit push_ok;
            push_ok = exp_ready && !model_eb;
            for (int i = 0; i < n; i++) void'(model_q.pop_front());
            if (push_ok) begin
                for (int i = 0; i < nvalid; i++) begin
                    model_q.push_back(uinstr_de0[i]);
                    if (uinstr_de0[i].uop == U_EBREAK) begin
                        model_eb = 1'b1;
                        break;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int nv, ebl, nr, phase;
        checks = 0;
        errors = 0;
        seq_id = 1;
        state_known = 1'b0;
        model_eb = 1'b0;
        reset = 1'b1;
        nuke_rb1 = '0;
        valid_de0 = '0;
        uinstr_de0 = '0;
        num_ready_rn0 = '0;
        @(negedge clk);
        applyStimulus(1, 0, 0, -1, 0);
        applyStimulus(1, 0, 2, -1, 2);

        // Single group through with full drain.
        applyStimulus(0, 0, 2, -1, 2);
        applyStimulus(0, 0, 0, -1, 2);
        applyStimulus(0, 0, 0, -1, 2);

        // Fill to capacity with rename stalled; fifth group is refused.
        for (int c = 0; c < 5; c++) applyStimulus(0, 0, 2, -1, 0);
        for (int c = 0; c < 5; c++) applyStimulus(0, 0, 0, -1, 2);

        // Steady state at six entries while pointers wrap.
        for (int c = 0; c < 3; c++) applyStimulus(0, 0, 2, -1, 0);
        for (int c = 0; c < 10; c++) applyStimulus(0, 0, 2, -1, 2);

        // Nuke at occupancy five with a push and pop offered.
        applyStimulus(0, 1, 0, -1, 0);
        applyStimulus(0, 0, 2, -1, 0);
        applyStimulus(0, 0, 2, -1, 0);
        applyStimulus(0, 0, 1, -1, 0);
        applyStimulus(0, 1, 2, -1, 2);
        applyStimulus(0, 0, 0, -1, 0);

        // EBREAK in lane 0 drops lane 1 and blocks later groups until nuke.
        applyStimulus(0, 0, 2, 0, 0);
        applyStimulus(0, 0, 2, -1, 0);
        applyStimulus(0, 0, 2, -1, 1);
        applyStimulus(0, 1, 2, -1, 0);
        applyStimulus(0, 0, 0, -1, 0);

        // One-cycle reset at occupancy four.
        applyStimulus(0, 0, 2, -1, 0);
        applyStimulus(0, 0, 2, -1, 0);
        applyStimulus(1, 0, 2, -1, 2);
        applyStimulus(0, 0, 0, -1, 0);

        for (int c = 0; c < 3000; c++) begin
            phase = (c / 100) % 3;
            nv  = $urandom_range(0, NI);
            ebl = ($urandom_range(0, 99) < 4 && nv > 0) ? int'($urandom_range(0, nv - 1)) : -1;
            case (phase)
                0:       nr = $urandom_range(0, 1);
                1:       nr = $urandom_range(0, NO);
                default: nr = NO;
            endcase
            applyStimulus($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 3, nv, ebl, nr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
